// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account arbiter: FSM encoding, default widths,
// and the round-robin wrap helper.
package atm_pkg;

    localparam int unsigned DEF_NUM_ATM       = 4;
    localparam int unsigned DEF_CARD_WIDTH    = 6;
    localparam int unsigned DEF_BALANCE_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } atm_state_t;

    // (base + off) mod n, for base < n and off < n
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/atm_rr_picker.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping past the top terminal.
module atm_rr_picker
    import atm_pkg::*;
#(
    parameter int unsigned num_atm = DEF_NUM_ATM,
    localparam int unsigned IDX_W  = $clog2(num_atm)
) (
    input  logic [num_atm-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_valid_c,
    output logic [IDX_W-1:0]   o_idx_c
);

    // Scan from farthest to nearest so the nearest requester wins
    always_comb begin
        o_valid_c = 1'b0;
        o_idx_c   = '0;
        for (int k = int'(num_atm) - 1; k >= 0; k--) begin
            if (i_req[IDX_W'(rr_wrap(32'(i_rr_ptr), 32'(k), num_atm))]) begin
                o_valid_c = 1'b1;
                o_idx_c   = IDX_W'(rr_wrap(32'(i_rr_ptr), 32'(k), num_atm));
            end
        end
    end

endmodule

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter sharing the single-port account balance store between
// ATM terminals. Each grant becomes one read or write access, then a one-cycle
// ack to the winner. Optional card lock table enabled by macro ACCT_LOCK_EN.
module atm_account_arbiter
    import atm_pkg::*;
#(
    parameter int unsigned num_atm       = DEF_NUM_ATM,
    parameter int unsigned card_width    = DEF_CARD_WIDTH,
    parameter int unsigned balance_width = DEF_BALANCE_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [num_atm-1:0]               req,
    input  logic [num_atm-1:0]               req_we,
    input  logic [num_atm*card_width-1:0]    req_card,
    input  logic [num_atm*balance_width-1:0] req_wdata,
    input  logic [num_atm-1:0]               sess_end,
    output logic [num_atm-1:0]               ack,
    output logic [num_atm-1:0]               req_err,
    output logic [balance_width-1:0]         rdata,
    output logic                             busy,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [card_width-1:0]            mem_addr,
    output logic [balance_width-1:0]         mem_wdata,
    input  logic [balance_width-1:0]         mem_rdata
);

    localparam int unsigned IDX_W = $clog2(num_atm);

    atm_state_t                 r_state, w_state_nx;
    logic [IDX_W-1:0]           r_grant, w_grant_nx;
    logic                       r_we, w_we_nx;
    logic [card_width-1:0]      r_card, w_card_nx;
    logic [balance_width-1:0]   r_wdata, w_wdata_nx;
    logic                       r_refused, w_refused_nx;
    logic [IDX_W-1:0]           r_rr_ptr, w_rr_ptr_nx;

    logic [num_atm-1:0]         r_ack, w_ack_nx;
    logic [num_atm-1:0]         r_req_err, w_req_err_nx;
    logic [balance_width-1:0]   r_rdata, w_rdata_nx;
    logic                       r_busy, w_busy_nx;
    logic                       r_mem_en, w_mem_en_nx;
    logic                       r_mem_we, w_mem_we_nx;
    logic [card_width-1:0]      r_mem_addr, w_mem_addr_nx;
    logic [balance_width-1:0]   r_mem_wdata, w_mem_wdata_nx;

    logic                       w_pick_vld;
    logic [IDX_W-1:0]           w_pick_idx;
    logic                       w_pick_we;
    logic [card_width-1:0]      w_pick_card;
    logic [balance_width-1:0]   w_pick_wdata;
    logic                       w_conflict;

    atm_rr_picker #(
        .num_atm (num_atm)
    ) u_picker (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_valid_c (w_pick_vld),
        .o_idx_c   (w_pick_idx)
    );

    assign w_pick_we    = req_we[w_pick_idx];
    assign w_pick_card  = req_card[32'(w_pick_idx) * card_width +: card_width];
    assign w_pick_wdata = req_wdata[32'(w_pick_idx) * balance_width +: balance_width];

`ifdef ACCT_LOCK_EN
    logic [num_atm-1:0]    r_lock_vld;
    logic [card_width-1:0] r_lock_card [num_atm];
    logic                  w_lock_set;

    // Refuse when another terminal holds a valid lock on the same card
    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < int'(num_atm); j++) begin
            if (r_lock_vld[j] && (r_lock_card[j] == w_pick_card) &&
                (IDX_W'(j) != w_pick_idx)) begin
                w_conflict = 1'b1;
            end
        end
    end

    assign w_lock_set = (r_state == IDLE) && w_pick_vld && !w_conflict;

    // Lock table: grant sets the owner's lock, sess_end clears it (grant wins)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_vld <= '0;
            for (int i = 0; i < int'(num_atm); i++) begin
                r_lock_card[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(num_atm); i++) begin
                if (w_lock_set && (w_pick_idx == IDX_W'(i))) begin
                    r_lock_vld[i]  <= 1'b1;
                    r_lock_card[i] <= w_pick_card;
                end else if (sess_end[i]) begin
                    r_lock_vld[i]  <= 1'b0;
                end
            end
        end
    end
`else
    logic w_unused_sess_end;

    assign w_conflict        = 1'b0;
    assign w_unused_sess_end = ^sess_end;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, latched operands and next values of the registered outputs
    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_we_nx      = r_we;
        w_card_nx    = r_card;
        w_wdata_nx   = r_wdata;
        w_refused_nx = r_refused;
        w_rr_ptr_nx  = r_rr_ptr;

        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nx   = w_pick_idx;
                    w_we_nx      = w_pick_we;
                    w_card_nx    = w_pick_card;
                    w_wdata_nx   = w_pick_wdata;
                    w_refused_nx = w_conflict;
                    w_state_nx   = w_conflict ? ACK : ISSUE;
                end
            end
            ISSUE:   w_state_nx = r_we ? ACK : CAPTURE;
            CAPTURE: w_state_nx = ACK;
            ACK: begin
                w_rr_ptr_nx = IDX_W'(rr_wrap(32'(r_grant), 32'd1, num_atm));
                w_state_nx  = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase

        w_ack_nx = '0;
        if (w_state_nx == ACK) begin
            w_ack_nx[w_grant_nx] = 1'b1;
        end
        w_req_err_nx = '0;
        if ((w_state_nx == ACK) && w_refused_nx) begin
            w_req_err_nx[w_grant_nx] = 1'b1;
        end
        w_busy_nx      = (w_state_nx != IDLE);
        w_mem_en_nx    = (w_state_nx == ISSUE);
        w_mem_we_nx    = w_mem_en_nx && w_we_nx;
        w_mem_addr_nx  = w_mem_en_nx ? w_card_nx : '0;
        w_mem_wdata_nx = w_mem_we_nx ? w_wdata_nx : '0;
        w_rdata_nx     = (r_state == CAPTURE) ? mem_rdata : r_rdata;
    end

    // Operand latches, round-robin pointer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant     <= '0;
            r_we        <= 1'b0;
            r_card      <= '0;
            r_wdata     <= '0;
            r_refused   <= 1'b0;
            r_rr_ptr    <= '0;
            r_ack       <= '0;
            r_req_err   <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_grant     <= w_grant_nx;
            r_we        <= w_we_nx;
            r_card      <= w_card_nx;
            r_wdata     <= w_wdata_nx;
            r_refused   <= w_refused_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_ack       <= w_ack_nx;
            r_req_err   <= w_req_err_nx;
            r_rdata     <= w_rdata_nx;
            r_busy      <= w_busy_nx;
            r_mem_en    <= w_mem_en_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
        end
    end

    assign ack       = r_ack;
    assign req_err   = r_req_err;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed testbench for atm_account_arbiter: vector table of single-terminal
// transactions plus hand-written round-robin, drop, reset and lock sequences.
module tb_atm_account_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 6;
    localparam int unsigned BW = 20;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      req_we;
    logic [N*CW-1:0]   req_card;
    logic [N*BW-1:0]   req_wdata;
    logic [N-1:0]      sess_end;
    logic [N-1:0]      ack;
    logic [N-1:0]      req_err;
    logic [BW-1:0]     rdata;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [CW-1:0]     mem_addr;
    logic [BW-1:0]     mem_wdata;
    logic [BW-1:0]     mem_rdata;

    logic [BW-1:0]     mem [64];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          idx;
        logic        we;
        logic [5:0]  card;
        logic [19:0] wdata;
        logic [19:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    atm_account_arbiter #(
        .num_atm       (N),
        .card_width    (CW),
        .balance_width (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_card  (req_card),
        .req_wdata (req_wdata),
        .sess_end  (sess_end),
        .ack       (ack),
        .req_err   (req_err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port store model, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One single-terminal transaction with latency/strobe accounting
    task automatic do_txn(input int idx, input logic we, input logic [5:0] card,
                          input logic [19:0] wd, input logic [19:0] exp_rd,
                          input int exp_lat, input logic exp_err, input int exp_men,
                          input logic rel, input string tag);
        int         cyc;
        int         men;
        int         bsy;
        logic       done;
        logic [3:0] ackv;
        logic [3:0] errv;
        logic [19:0] rdv;
        logic [3:0] exp_ack;
        cyc = 0; men = 0; bsy = 0; done = 1'b0; ackv = '0; errv = '0; rdv = '0;
        exp_ack = '0;
        exp_ack[idx] = 1'b1;
        @(negedge clk);
        req[idx]               = 1'b1;
        req_we[idx]            = we;
        req_card[idx*CW +: CW] = card;
        req_wdata[idx*BW +: BW] = wd;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (busy) bsy++;
            if (mem_en) begin
                men++;
                chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
                chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(card));
                if (we) chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(wd));
            end
            if (ack != '0) begin
                done = 1'b1;
                ackv = ack;
                errv = req_err;
                rdv  = rdata;
            end
        end
        req[idx] = 1'b0;
        if (rel) sess_end[idx] = 1'b1;
        chk({tag, "_ack"}, 32'(ackv), 32'(exp_ack));
        chk({tag, "_latency"}, 32'(cyc + 1), 32'(exp_lat));
        chk({tag, "_req_err"}, 32'(errv), exp_err ? 32'(exp_ack) : 32'd0);
        chk({tag, "_rdata"}, 32'(rdv), 32'(exp_rd));
        chk({tag, "_mem_en_count"}, 32'(men), 32'(exp_men));
        chk({tag, "_busy_cycles"}, 32'(bsy), 32'(exp_lat - 1));
        @(negedge clk);
        sess_end = '0;
        chk({tag, "_ack_one_cycle"}, 32'(ack), 32'd0);
    endtask

    initial begin
        vec_t        vecs [8];
        logic [3:0]  rr_ack [5];
        logic [19:0] rr_rd [5];
        int          got;
        int          cyc;

        vecs[0] = '{1, 1'b0, 6'd5,  20'd0,      20'd1500,   4};
        vecs[1] = '{2, 1'b1, 6'd9,  20'd750,    20'd1500,   3};
        vecs[2] = '{0, 1'b0, 6'd9,  20'd0,      20'd750,    4};
        vecs[3] = '{3, 1'b0, 6'd63, 20'd0,      20'hFFFFF,  4};
        vecs[4] = '{3, 1'b1, 6'd0,  20'hABCDE,  20'hFFFFF,  3};
        vecs[5] = '{2, 1'b0, 6'd0,  20'd0,      20'hABCDE,  4};
        vecs[6] = '{0, 1'b1, 6'd63, 20'd1,      20'hABCDE,  3};
        vecs[7] = '{1, 1'b0, 6'd63, 20'd0,      20'd1,      4};

        rr_ack[0] = 4'b0001; rr_ack[1] = 4'b0010; rr_ack[2] = 4'b0100;
        rr_ack[3] = 4'b1000; rr_ack[4] = 4'b0001;
        rr_rd[0] = 20'd1500; rr_rd[1] = 20'd750; rr_rd[2] = 20'hABCDE;
        rr_rd[3] = 20'd1;    rr_rd[4] = 20'd1500;

        for (int a = 0; a < 64; a++) mem[a] = '0;
        mem[5]  = 20'd1500;
        mem[7]  = 20'd321;
        mem[63] = 20'hFFFFF;
        mem_rdata = '0;

        rst = 1'b1; req = '0; req_we = '0; req_card = '0; req_wdata = '0; sess_end = '0;
        repeat (2) @(negedge clk);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_req_err", 32'(req_err), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].idx, vecs[v].we, vecs[v].card, vecs[v].wdata,
                   vecs[v].exp_rdata, vecs[v].exp_lat, 1'b0,
                   1, 1'b1, $sformatf("vec%0d", v));
        end

        // All four requesting and held: order from a fresh pointer
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_we = '0;
        req_card = {6'd63, 6'd0, 6'd9, 6'd5};
        req = 4'hF;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                chk("rr_single_ack", 32'($onehot(ack)), 32'd1);
                chk($sformatf("rr_order%0d", got), 32'(ack), 32'(rr_ack[got]));
                chk($sformatf("rr_rdata%0d", got), 32'(rdata), 32'(rr_rd[got]));
                got++;
                if (got == 5) begin
                    req = '0;
                    sess_end = 4'hF;
                end
            end
        end
        chk("rr_ack_count", 32'(got), 32'd5);
        @(negedge clk);
        sess_end = '0;

        // T3 drops req during CAPTURE; the access still completes
        req[3] = 1'b1; req_we[3] = 1'b0; req_card[3*CW +: CW] = 6'd9;
        @(negedge clk);
        @(negedge clk);
        chk("drop_busy_capture", 32'(busy), 32'd1);
        req[3] = 1'b0;
        cyc = 0;
        while (ack == '0 && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        chk("drop_ack", 32'(ack), 32'b1000);
        chk("drop_ack_delay", 32'(cyc), 32'd1);
        chk("drop_rdata", 32'(rdata), 32'd750);
        sess_end[3] = 1'b1;
        @(negedge clk);
        sess_end = '0;

        // Reset during ISSUE aborts the write with no ack
        req[0] = 1'b1; req_we[0] = 1'b1; req_card[0 +: CW] = 6'd5; req_wdata[0 +: BW] = 20'd999;
        @(negedge clk);
        chk("abort_in_issue", 32'(mem_en), 32'd1);
        rst = 1'b1;
        req = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_ack", 32'(ack), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_mem_en", 32'(mem_en), 32'd0);
        end
        chk("abort_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        do_txn(1, 1'b0, 6'd5, 20'd0, 20'd1500, 4, 1'b0, 1, 1'b1, "after_abort");

`ifdef ACCT_LOCK_EN
        do_txn(0, 1'b0, 6'd7, 20'd0, 20'd321, 4, 1'b0, 1, 1'b0, "lock_owner");
        do_txn(1, 1'b0, 6'd7, 20'd0, 20'd321, 2, 1'b1, 0, 1'b0, "lock_refused");
        @(negedge clk);
        sess_end[0] = 1'b1;
        @(negedge clk);
        sess_end = '0;
        do_txn(1, 1'b0, 6'd7, 20'd0, 20'd321, 4, 1'b0, 1, 1'b1, "lock_retry");
`else
        do_txn(0, 1'b0, 6'd7, 20'd0, 20'd321, 4, 1'b0, 1, 1'b0, "nolock_first");
        do_txn(1, 1'b0, 6'd7, 20'd0, 20'd321, 4, 1'b0, 1, 1'b1, "nolock_same_card");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/atm_account_arbiter.md
Name: atm_account_arbiter

Overview:
- Shares the single-port account balance store between num_atm ATM front-ends (each an ATM_FSM/card_handling pair).
- Round-robin arbitration; each granted request is sequenced as one read or write access to the store.
- Returns read data and a one-cycle ack to the winning terminal.
- Sits between the terminal instances and the account memory inside the bank-level top.

Parameters:
- num_atm, 4, number of requesting terminals (2..8)
- card_width, 6, card number width = store address width
- balance_width, 20, balance word width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req  input  num_atm  per-terminal request, level, held until ack
- req_we  input  num_atm  1 = write balance, 0 = read balance
- req_card  input  num_atm*card_width  card number, terminal i at slice [i*card_width +: card_width]
- req_wdata  input  num_atm*balance_width  write balance, same slicing
- sess_end  input  num_atm  pulse: terminal ejected card (lock release)
- ack  output  num_atm  one-hot, one-cycle completion pulse
- req_err  output  num_atm  valid with ack: request refused (lock conflict)
- rdata  output  balance_width  read balance, valid with ack, held until the next ack
- busy  output  1  high from grant until ack cycle inclusive
- mem_en  output  1  store access strobe
- mem_we  output  1  store write enable
- mem_addr  output  card_width  store address
- mem_wdata  output  balance_width  store write data
- mem_rdata  input  balance_width  store read data, valid 1 cycle after mem_en&&!mem_we

Behaviour:
- Reset: all outputs 0, FSM IDLE, rr pointer 0, lock table cleared; reset mid-transaction aborts with no ack.
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE: if any req, grant the first set bit scanning from rr_ptr upward, with wrap. Latch grant index, we, card and wdata, then go to ISSUE; busy rises.
- ISSUE: drive mem_en=1, mem_we, mem_addr and mem_wdata for exactly one cycle. Next state is CAPTURE for a read, ACK for a write.
- CAPTURE: register mem_rdata into rdata, then go to ACK.
- ACK: ack[grant]=1 for one cycle; rr_ptr = (grant+1) mod num_atm; return to IDLE. The earliest re-grant is the following cycle.
- Latency from req sampled in IDLE to ack: read 4 cycles, write 3 cycles.
- req is sampled only in IDLE. A req dropped after grant does not cancel: the access completes and ack still pulses.
- A requester that does not drop req after ack is eligible again, behind the others per round-robin.
- Only the granted terminal's operands are latched; other terminals' inputs may change freely.
- Single requester: it is granted every turn regardless of rr_ptr.
- rr_ptr wraps from num_atm-1 to 0.
- No arithmetic is performed; balance words pass through unmodified.

Optional Feature:
- Macro ACCT_LOCK_EN.
- With the macro:
  - Each terminal owns a lock register {valid, card}. Any granted access sets the granted terminal's lock to its card.
  - A request whose card equals another terminal's valid lock is refused: FSM goes IDLE->ACK directly (no mem_en), ack and req_err pulse together, rdata is unchanged.
  - sess_end[i] clears lock i. If sess_end and a grant to the same terminal occur in the same cycle, the grant wins.
- Without the macro: no lock table, sess_end ignored, req_err tied 0.

Decomposition:
- Shared package (atm_pkg): state encoding constants (IDLE/ISSUE/CAPTURE/ACK), default widths.
- One sub-module: atm_rr_picker, combinational round-robin selector (req vector, rr_ptr -> grant valid + index).

Test Plan:
- Reset, then T1 reads card 5 (mem_rdata=20'd1500) -> one mem_en with we=0, addr=5; ack=4'b0010 four cycles after req; rdata=1500; busy high 3 cycles.
- T2 writes 20'd750 to card 9 -> mem_en=1, mem_we=1, addr=9, wdata=750 in one cycle; ack=4'b0100 three cycles after req.
- All four req high and held -> grant order T0,T1,T2,T3,T0; rr_ptr wraps; no two acks in the same cycle.
- T3 drops req during CAPTURE -> ack[3] still pulses, rdata valid; rst asserted during ISSUE -> outputs 0 next edge, no ack.
- ACCT_LOCK_EN: T0 reads card 7, then T1 reads card 7 -> T1 ack+req_err with no mem_en. After T0 sess_end, T1 retries -> normal read completes, req_err=0.
